// File: rtl/hazard_ctrl.sv
// Pipeline hazard and stall controller for the 7-stage core: load-use detection,
// divider sequencing, cache-miss stall patterns and a registered exception flush.
module hazard_ctrl #(
  parameter int STALL_W = 6,
  parameter int PC_W    = 32,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               id_rs_re,
  input  logic [4:0]         id_rs_addr,
  input  logic               id_rt_re,
  input  logic [4:0]         id_rt_addr,
  input  logic               ex_we,
  input  logic [4:0]         ex_waddr,
  input  logic               ex_is_load,
  input  logic               dc_we,
  input  logic [4:0]         dc_waddr,
  input  logic               dc_is_load,
  input  logic               ex_is_div,
  input  logic               div_ready,
  input  logic               if_miss,
  input  logic               dc_miss,
  input  logic               excp_valid,
  input  logic [PC_W-1:0]    excp_target,
  output logic [STALL_W-1:0] stall,
  output logic               flush,
  output logic [PC_W-1:0]    new_pc,
  output logic               div_start,
  output logic               div_cancel,
  output logic [CNT_W-1:0]   stall_cnt
);

  typedef enum logic [1:0] {
    D_IDLE = 2'd0,
    D_BUSY = 2'd1,
    D_HOLD = 2'd2
  } div_state_e;

  localparam logic [STALL_W-1:0] STALL_EXCP = STALL_W'(6'b111111);
  localparam logic [STALL_W-1:0] STALL_DC   = STALL_W'(6'b011111);
  localparam logic [STALL_W-1:0] STALL_DIV  = STALL_W'(6'b001111);
  localparam logic [STALL_W-1:0] STALL_LU   = STALL_W'(6'b000111);
  localparam logic [STALL_W-1:0] STALL_IF   = STALL_W'(6'b000011);

  div_state_e         state, state_nxt;
  logic               rs_hit, rt_hit, lu;
  logic               div_busy;
  logic               flush_take;
  logic [STALL_W-1:0] stall_raw;

  // Load data only becomes forwardable in MEM, so a load in EX or DC must hold ID.
  always_comb begin
    rs_hit = id_rs_re && (id_rs_addr != 5'd0) &&
             ((ex_is_load && ex_we && (ex_waddr == id_rs_addr)) ||
              (dc_is_load && dc_we && (dc_waddr == id_rs_addr)));
    rt_hit = id_rt_re && (id_rt_addr != 5'd0) &&
             ((ex_is_load && ex_we && (ex_waddr == id_rt_addr)) ||
              (dc_is_load && dc_we && (dc_waddr == id_rt_addr)));
    lu     = rs_hit || rt_hit;
  end

  assign flush_take = excp_valid && !flush;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= D_IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    if (flush_take) begin
      state_nxt = D_IDLE;
    end else begin
      case (state)
        D_IDLE:  if (div_start) state_nxt = D_BUSY;
        D_BUSY:  if (div_ready) state_nxt = stall_raw[3] ? D_HOLD : D_IDLE;
        D_HOLD:  if (!stall_raw[3]) state_nxt = D_IDLE;
        default: state_nxt = D_IDLE;
      endcase
    end
  end

  // Output logic; a flush cycle masks every stall cause, reset forces all outputs low.
  always_comb begin
    // NOTE: every variable gets a default first so no path through the block infers a latch.
    div_busy   = 1'b0;
    stall_raw  = '0;
    div_start  = 1'b0;
    div_cancel = 1'b0;

    case (state)
      D_IDLE:  div_busy = ex_is_div;
      D_BUSY:  div_busy = !div_ready;
      default: div_busy = 1'b0;
    endcase

    if (flush)           stall_raw = '0;
    else if (excp_valid) stall_raw = STALL_EXCP;
    else if (dc_miss)    stall_raw = STALL_DC;
    else if (div_busy)   stall_raw = STALL_DIV;
    else if (lu)         stall_raw = STALL_LU;
    else if (if_miss)    stall_raw = STALL_IF;

    // Only excp and dc_miss outrank the divider's own hold on EX.
    div_start  = !rst && (state == D_IDLE) && ex_is_div &&
                 !flush && !excp_valid && !dc_miss;
    div_cancel = !rst && (state == D_BUSY) && flush_take;
    stall      = rst ? '0 : stall_raw;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush     <= 1'b0;
      new_pc    <= '0;
      stall_cnt <= '0;
    end else begin
      flush <= flush_take;
      if (flush_take) new_pc <= excp_target;
      if (|stall) stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: stimulus pushes hand-computed per-cycle
// expectations, a negedge monitor pops and compares every output.
module tb_hazard_ctrl;

  localparam logic [31:0] PC_X = 32'hBFC00380;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        id_rs_re, id_rt_re, ex_we, ex_is_load, dc_we, dc_is_load;
  logic [4:0]  id_rs_addr, id_rt_addr, ex_waddr, dc_waddr;
  logic        ex_is_div, div_ready, if_miss, dc_miss, excp_valid;
  logic [31:0] excp_target;
  logic [5:0]  stall;
  logic        flush, div_start, div_cancel;
  logic [31:0] new_pc, stall_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        div_start;
    logic        div_cancel;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb[$];

  hazard_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .id_rs_re   (id_rs_re),
    .id_rs_addr (id_rs_addr),
    .id_rt_re   (id_rt_re),
    .id_rt_addr (id_rt_addr),
    .ex_we      (ex_we),
    .ex_waddr   (ex_waddr),
    .ex_is_load (ex_is_load),
    .dc_we      (dc_we),
    .dc_waddr   (dc_waddr),
    .dc_is_load (dc_is_load),
    .ex_is_div  (ex_is_div),
    .div_ready  (div_ready),
    .if_miss    (if_miss),
    .dc_miss    (dc_miss),
    .excp_valid (excp_valid),
    .excp_target(excp_target),
    .stall      (stall),
    .flush      (flush),
    .new_pc     (new_pc),
    .div_start  (div_start),
    .div_cancel (div_cancel),
    .stall_cnt  (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: outputs are sampled mid-cycle, away from the rising edge.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check({e.name, ".stall"},      64'(stall),      64'(e.stall));
      check({e.name, ".flush"},      64'(flush),      64'(e.flush));
      check({e.name, ".new_pc"},     64'(new_pc),     64'(e.new_pc));
      check({e.name, ".div_start"},  64'(div_start),  64'(e.div_start));
      check({e.name, ".div_cancel"}, 64'(div_cancel), 64'(e.div_cancel));
      check({e.name, ".stall_cnt"},  64'(stall_cnt),  64'(e.cnt));
    end
  end

  task automatic clear_inputs();
    id_rs_re = 0; id_rs_addr = 0; id_rt_re = 0; id_rt_addr = 0;
    ex_we = 0; ex_waddr = 0; ex_is_load = 0;
    dc_we = 0; dc_waddr = 0; dc_is_load = 0;
    ex_is_div = 0; div_ready = 0; if_miss = 0; dc_miss = 0;
    excp_valid = 0; excp_target = 0;
  endtask

  task automatic cyc(input string nm, input logic [5:0] st, input logic fl,
                     input logic [31:0] pc, input logic ds, input logic dc,
                     input logic [31:0] cnt);
    exp_t e;
    e.name = nm; e.stall = st; e.flush = fl; e.new_pc = pc;
    e.div_start = ds; e.div_cancel = dc; e.cnt = cnt;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    clear_inputs();
    @(posedge clk);
    #1;
    // Reset masks outputs even with active causes present.
    ex_is_div = 1; dc_miss = 1; excp_valid = 1; if_miss = 1;
    cyc("reset", 6'b000000, 0, 0, 0, 0, 0);
    rst = 0; clear_inputs();
    cyc("idle", 6'b000000, 0, 0, 0, 0, 0);

    // Load-use: load in EX then DC, two bubbles
    ex_is_load = 1; ex_we = 1; ex_waddr = 5; id_rs_re = 1; id_rs_addr = 5;
    cyc("lu_ex", 6'b000111, 0, 0, 0, 0, 0);
    ex_is_load = 0; ex_we = 0; dc_is_load = 1; dc_we = 1; dc_waddr = 5;
    cyc("lu_dc", 6'b000111, 0, 0, 0, 0, 1);
    dc_is_load = 0; dc_we = 0;
    cyc("lu_mem", 6'b000000, 0, 0, 0, 0, 2);
    ex_is_load = 1; ex_we = 1; ex_waddr = 0; id_rs_addr = 0;
    cyc("lu_r0_ex", 6'b000000, 0, 0, 0, 0, 2);
    ex_is_load = 0; ex_we = 0; dc_is_load = 1; dc_we = 1; dc_waddr = 0;
    cyc("lu_r0_dc", 6'b000000, 0, 0, 0, 0, 2);
    clear_inputs();
    dc_is_load = 1; dc_we = 1; dc_waddr = 7; id_rt_re = 1; id_rt_addr = 7;
    cyc("lu_rt", 6'b000111, 0, 0, 0, 0, 2);
    clear_inputs();
    ex_we = 1; ex_waddr = 7; id_rt_re = 1; id_rt_addr = 7;
    cyc("alu_fwd", 6'b000000, 0, 0, 0, 0, 3);
    clear_inputs();

    // Divide: start, 7 busy cycles, ready on the 8th
    ex_is_div = 1;
    cyc("div_start", 6'b001111, 0, 0, 1, 0, 3);
    for (int i = 0; i < 7; i++) cyc("div_busy", 6'b001111, 0, 0, 0, 0, 32'(4 + i));
    div_ready = 1;
    cyc("div_ready", 6'b000000, 0, 0, 0, 0, 11);
    ex_is_div = 0; div_ready = 0;
    cyc("div_done", 6'b000000, 0, 0, 0, 0, 11);

    // Divide completing under a dcache miss parks in D_HOLD
    ex_is_div = 1;
    cyc("dh_start", 6'b001111, 0, 0, 1, 0, 11);
    cyc("dh_busy0", 6'b001111, 0, 0, 0, 0, 12);
    cyc("dh_busy1", 6'b001111, 0, 0, 0, 0, 13);
    div_ready = 1; dc_miss = 1;
    cyc("dh_ready", 6'b011111, 0, 0, 0, 0, 14);
    div_ready = 0;
    cyc("dh_hold", 6'b011111, 0, 0, 0, 0, 15);
    dc_miss = 0;
    cyc("dh_release", 6'b000000, 0, 0, 0, 0, 16);
    ex_is_div = 0;
    cyc("dh_after", 6'b000000, 0, 0, 0, 0, 16);

    // dc_miss outranks the divider: start deferred until it clears
    ex_is_div = 1; dc_miss = 1;
    cyc("div_defer", 6'b011111, 0, 0, 0, 0, 16);
    dc_miss = 0;
    cyc("div_accept", 6'b001111, 0, 0, 1, 0, 17);
    cyc("ex_busy", 6'b001111, 0, 0, 0, 0, 18);

    // Exception mid-divide: cancel, then one-cycle flush
    excp_valid = 1; excp_target = PC_X;
    cyc("excp", 6'b111111, 0, 0, 0, 1, 19);
    dc_miss = 1; if_miss = 1; excp_target = 32'h1234_5678;
    cyc("flush", 6'b000000, 1, PC_X, 0, 0, 20);
    clear_inputs();
    cyc("post_flush", 6'b000000, 0, PC_X, 0, 0, 20);

    // Priority
    if_miss = 1; dc_miss = 1;
    cyc("pri_dc_if", 6'b011111, 0, PC_X, 0, 0, 20);
    dc_miss = 0;
    cyc("pri_if", 6'b000011, 0, PC_X, 0, 0, 21);
    ex_is_load = 1; ex_we = 1; ex_waddr = 3; id_rs_re = 1; id_rs_addr = 3;
    cyc("pri_lu_if", 6'b000111, 0, PC_X, 0, 0, 22);
    dc_miss = 1;
    cyc("pri_dc_lu", 6'b011111, 0, PC_X, 0, 0, 23);
    clear_inputs();
    cyc("pre_rst", 6'b000000, 0, PC_X, 0, 0, 24);

    // Counter from a fresh reset, then asynchronous reset mid-cycle
    rst = 1;
    cyc("rst2", 6'b000000, 0, 0, 0, 0, 0);
    rst = 0; if_miss = 1;
    cyc("cnt0", 6'b000011, 0, 0, 0, 0, 0);
    cyc("cnt1", 6'b000011, 0, 0, 0, 0, 1);
    cyc("cnt2", 6'b000011, 0, 0, 0, 0, 2);
    if_miss = 0;
    cyc("cnt3", 6'b000000, 0, 0, 0, 0, 3);
    ex_is_div = 1; if_miss = 1;
    #2 rst = 1;
    cyc("async_rst", 6'b000000, 0, 0, 0, 0, 0);
    rst = 0; clear_inputs();
    cyc("after_rst", 6'b000000, 0, 0, 0, 0, 0);

    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Central pipeline hazard and stall controller for the 7-stage core: PC, IF, ID, EX, DC (dcache), MEM, WB.
- Generates the stall bus shared by all stage registers and the forwarding unit.
- Detects load-use hazards, which forwarding cannot cover, and sequences the multi-cycle divider.
- Turns icache/dcache miss stalls and MEM-stage exceptions into stall patterns and a registered flush with redirect PC.

Parameters:
- STALL_W, 6, stall bus width; bit i holds stage i: [0]=PC [1]=IF [2]=ID [3]=EX [4]=DC [5]=MEM.
- PC_W, 32, width of redirect PC.
- CNT_W, 32, width of stall-cycle performance counter.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- id_rs_re  in  1  ID reads rs.
- id_rs_addr  in  5  rs address.
- id_rt_re  in  1  ID reads rt.
- id_rt_addr  in  5  rt address.
- ex_we  in  1  EX instruction writes a GPR.
- ex_waddr  in  5  EX write address.
- ex_is_load  in  1  EX instruction is a load.
- dc_we  in  1  DC instruction writes a GPR.
- dc_waddr  in  5  DC write address.
- dc_is_load  in  1  DC instruction is a load.
- ex_is_div  in  1  EX holds a div/divu/mult instruction.
- div_ready  in  1  divider result valid; one-cycle pulse.
- if_miss  in  1  icache not ready this cycle.
- dc_miss  in  1  dcache not ready this cycle.
- excp_valid  in  1  exception/eret committing in MEM.
- excp_target  in  PC_W  redirect address.
- stall  out  STALL_W  stall bus.
- flush  out  1  flush all stage registers.
- new_pc  out  PC_W  redirect PC; valid while flush=1.
- div_start  out  1  start divider; one-cycle pulse.
- div_cancel  out  1  abort divider.
- stall_cnt  out  CNT_W  count of cycles with stall!=0.

Behaviour:
- Reset and idle values:
  - While rst=1, every output is 0, the FSM is in D_IDLE, and stall_cnt=0.
  - rst asserting mid-divide aborts the sequence silently; div_cancel stays 0.
- Load-use hazard (lu), combinational, for r in {rs, rt}:
  - Condition: re && addr!=0 && ((ex_is_load && ex_we && ex_waddr==addr) || (dc_is_load && dc_we && dc_waddr==addr)).
  - Load data is forwardable only once the load reaches MEM. A load in EX therefore costs 2 bubbles; a load in DC costs 1.
- Stall priority, highest first; only the first matching pattern drives stall:
  1. excp_valid && !flush → 6'b111111.
  2. dc_miss → 6'b011111.
  3. div_busy → 6'b001111.
  4. lu → 6'b000111.
  5. if_miss → 6'b000011.
  6. otherwise 6'b000000.
- A bubble enters stage i+1 when stall[i]=1 and stall[i+1]=0.
- Flush:
  - Registered. At the edge after excp_valid=1 with flush=0: flush=1 and new_pc=excp_target, for exactly one cycle.
  - While flush=1: stall=0, excp_valid is ignored, and all other stall causes are masked.
  - new_pc holds its last value after flush deasserts.
- Divider FSM (2-bit state):
  - D_IDLE:
    - div_start=ex_is_div && stall[3]==0 && !flush && !excp_valid.
    - ex_is_div && !flush → D_BUSY. div_busy=ex_is_div, so EX holds in the first cycle too.
  - D_BUSY:
    - div_busy=!div_ready.
    - On div_ready: if the final stall[3]==0 → D_IDLE; else → D_HOLD.
    - div_start is never asserted in this state.
  - D_HOLD:
    - Result latched downstream; div_busy=0; no div_start.
    - Go to D_IDLE when stall[3]==0.
  - In any state, excp_valid && !flush → D_IDLE next cycle, with div_cancel=1 that cycle if state was D_BUSY.
  - Correction to D_IDLE for priority: div_start is asserted only when ex_is_div is high and no higher-priority cause (excp, dc_miss) holds EX. It is re-evaluated each cycle until accepted; the D_BUSY transition occurs only in the cycle div_start=1.
- stall_cnt:
  - +1 every cycle with stall!=0.
  - Wraps modulo 2^CNT_W; 0xFFFFFFFF→0.
- All outputs except flush, new_pc and stall_cnt are combinational from inputs and state.

Test Plan:
- Load-use: ex_is_load=1, ex_we=1, ex_waddr=5; next cycle dc_is_load=1, dc_waddr=5; ID id_rs_re=1, id_rs_addr=5 → stall=6'b000111 for 2 consecutive cycles, then 0; same with addr=0 → stall=0 throughout.
- Divide: ex_is_div=1, div_ready after 8 cycles → div_start=1 for exactly 1 cycle; stall=6'b001111 from that cycle until the div_ready cycle; stall=0 on the ready cycle; FSM back in D_IDLE.
- Div + dc_miss: dc_miss=1 during the div_ready cycle → stall=6'b011111, FSM enters D_HOLD; no second div_start when dc_miss drops.
- Exception mid-divide: excp_valid=1, excp_target=0xBFC00380 while in D_BUSY → stall=6'b111111 and div_cancel=1 that cycle; next cycle flush=1, new_pc=0xBFC00380, stall=0; following cycle flush=0.
- Priority: if_miss=1 with dc_miss=1 → 6'b011111; if_miss alone → 6'b000011.
- stall_cnt: preload via 3 stalled cycles → stall_cnt=3; async rst pulse mid-cycle → all outputs 0 immediately, stall_cnt=0.
